// File: rtl/ula_pipe.sv
// WIDTH-generic ALU, one request in flight; 1-cycle latency, DIV takes WIDTH cycles (restoring radix-2).
// Backpressure: a result is held stable until out_ready; a new request is taken on the consuming edge.
module ula_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_carry,
    output logic                 out_err,
    output logic [TAG_W-1:0]     out_tag
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_REV = 4'd8;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]           state;
    logic [WIDTH-1:0]     div_rem;
    logic [WIDTH-1:0]     div_quo;
    logic [WIDTH-1:0]     div_dsr;
    logic [CNT_W-1:0]     div_cnt;
    logic [TAG_W-1:0]     div_tag;
    logic                 div_zero;

    logic                 accept;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   alu_result;
    logic                 alu_carry;
    logic                 alu_err;

    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH-1:0]     nxt_rem;
    logic [WIDTH-1:0]     nxt_quo;

    assign in_ready = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum        = {1'b0, in_a} + {1'b0, in_b};
        diff       = {1'b0, in_a} - {1'b0, in_b};
        prod       = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_err    = 1'b0;
        case (in_op)
            OP_ADD: begin
                alu_result[WIDTH:0] = sum;
                alu_carry           = sum[WIDTH];
            end
            OP_SUB: begin
                // Bit WIDTH of the widened difference is the borrow (a < b).
                alu_result[WIDTH-1:0] = diff[WIDTH-1:0];
                alu_carry             = diff[WIDTH];
            end
            OP_MUL: alu_result = prod;
            OP_DIV: alu_err = 1'b0;
            OP_AND: alu_result[WIDTH-1:0] = in_a & in_b;
            OP_OR:  alu_result[WIDTH-1:0] = in_a | in_b;
            OP_XOR: alu_result[WIDTH-1:0] = in_a ^ in_b;
            OP_REV: begin
                for (int i = 0; i < WIDTH; i++) begin
                    alu_result[i] = in_a[WIDTH-1-i];
                end
            end
            default: alu_err = 1'b1;
        endcase
    end

    // Restoring step; a zero divisor naturally yields all-ones quotient and remainder = dividend.
    always_comb begin
        div_shift = {div_rem, div_quo[WIDTH-1]};
        div_trial = div_shift - {1'b0, div_dsr};
        if (!div_trial[WIDTH]) begin
            nxt_rem = div_trial[WIDTH-1:0];
            nxt_quo = {div_quo[WIDTH-2:0], 1'b1};
        end else begin
            nxt_rem = div_shift[WIDTH-1:0];
            nxt_quo = {div_quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_err    <= 1'b0;
            out_tag    <= '0;
            div_rem    <= '0;
            div_quo    <= '0;
            div_dsr    <= '0;
            div_cnt    <= '0;
            div_tag    <= '0;
            div_zero   <= 1'b0;
        end else begin
            case (state)
                S_DIV: begin
                    div_rem <= nxt_rem;
                    div_quo <= nxt_quo;
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == CNT_LAST) begin
                        out_result <= {nxt_rem, nxt_quo};
                        out_carry  <= 1'b0;
                        out_err    <= div_zero;
                        out_tag    <= div_tag;
                        out_valid  <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                default: begin
                    if (state == S_HOLD && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                    if (accept) begin
                        if (in_op == OP_DIV) begin
                            div_rem   <= '0;
                            div_quo   <= in_a;
                            div_dsr   <= in_b;
                            div_cnt   <= '0;
                            div_tag   <= in_tag;
                            div_zero  <= (in_b == '0);
                            out_valid <= 1'b0;
                            state     <= S_DIV;
                        end else begin
                            out_result <= alu_result;
                            out_carry  <= alu_carry;
                            out_err    <= alu_err;
                            out_tag    <= in_tag;
                            out_valid  <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end
                end
            endcase
        end
    end

endmodule
